// File: rtl/lb_pkg.sv
// Default geometry of the windowed line buffer and the derived sample width.
package lb_pkg;

  localparam int unsigned LB_INTEGER_BITS     = 9;
  localparam int unsigned LB_FIXED_POINT_BITS = 4;
  localparam int unsigned LB_DEPTH            = 512;
  localparam int unsigned LB_KERNEL           = 3;
  localparam int unsigned LB_STRIDE           = 1;
  localparam int unsigned W                   = LB_INTEGER_BITS + LB_FIXED_POINT_BITS;

endpackage

// File: rtl/window_line_buffer_if.sv
// Sample-write / window-read bundle of the line buffer; slave is the buffer side.
interface window_line_buffer_if
  import lb_pkg::*;
#(
  parameter int unsigned DATA_W  = W,
  parameter int unsigned KERNEL  = LB_KERNEL,
  parameter int unsigned COUNT_W = $clog2(LB_DEPTH) + 1
);

  logic                       i_clear;
  logic [DATA_W-1:0]          i_data;
  logic                       i_data_valid;
  logic                       o_full;
  logic                       i_rd_data;
  logic                       o_win_valid;
  logic [DATA_W*KERNEL-1:0]   o_data;
  logic [COUNT_W-1:0]         o_count;
  logic                       o_overflow;
  logic                       o_underflow;

  modport master (
    output i_clear, i_data, i_data_valid, i_rd_data,
    input  o_full, o_win_valid, o_data, o_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_clear, i_data, i_data_valid, i_rd_data,
    output o_full, o_win_valid, o_data, o_count, o_overflow, o_underflow
  );

endinterface

// File: rtl/lb_window_mem.sv
// Sample storage: one synchronous write port, KERNEL combinational read ports at
// consecutive (wrapping) addresses; port 0 is the oldest sample and lands in the MSB slice.
module lb_window_mem #(
  parameter int unsigned DATA_W = 13,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned KERNEL = 3,
  localparam int unsigned AddrW = $clog2(DEPTH)
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [AddrW-1:0]         i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [AddrW-1:0]         i_raddr,
  output logic [DATA_W*KERNEL-1:0] o_rdata
);

  // No reset: contents are meaningless until written.
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  for (genvar k = 0; k < KERNEL; k++) begin : g_rd
    logic [AddrW-1:0] w_addr;
    // DEPTH is a power of two, so the natural pointer overflow is the wrap.
    assign w_addr = i_raddr + AddrW'(k);
    assign o_rdata[(KERNEL-1-k)*DATA_W +: DATA_W] = r_mem[w_addr];
  end

endmodule

// File: rtl/window_line_buffer.sv
// Circular line buffer presenting a sliding KERNEL-sample window that advances by STRIDE.
module window_line_buffer
  import lb_pkg::*;
#(
  parameter int unsigned INTEGER_BITS     = LB_INTEGER_BITS,
  parameter int unsigned FIXED_POINT_BITS = LB_FIXED_POINT_BITS,
  parameter int unsigned DEPTH            = LB_DEPTH,
  parameter int unsigned KERNEL           = LB_KERNEL,
  parameter int unsigned STRIDE           = LB_STRIDE
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  window_line_buffer_if.slave io_bus
);

  localparam int unsigned DataW  = INTEGER_BITS + FIXED_POINT_BITS;
  localparam int unsigned AddrW  = $clog2(DEPTH);
  localparam int unsigned CountW = AddrW + 1;

  logic [AddrW-1:0]  r_wr_ptr, w_wr_ptr_nxt;
  logic [AddrW-1:0]  r_rd_ptr, w_rd_ptr_nxt;
  logic [CountW-1:0] r_count, w_count_nxt;
  logic              r_overflow, w_overflow_nxt;
  logic              r_underflow, w_underflow_nxt;
  logic              w_full, w_win_valid, w_wr_accept, w_rd_accept, w_mem_we;

  // Full is judged before any same-cycle read, so a read never makes room for a write.
  assign w_full      = (r_count == CountW'(DEPTH));
  assign w_win_valid = (r_count >= CountW'(KERNEL));
  assign w_wr_accept = io_bus.i_data_valid && !w_full;
  assign w_rd_accept = io_bus.i_rd_data && w_win_valid;
  assign w_mem_we    = w_wr_accept && !io_bus.i_clear;

  always_comb begin
    w_wr_ptr_nxt    = r_wr_ptr;
    w_rd_ptr_nxt    = r_rd_ptr;
    w_count_nxt     = r_count;
    w_overflow_nxt  = r_overflow;
    w_underflow_nxt = r_underflow;
    if (io_bus.i_clear) begin
      w_wr_ptr_nxt    = '0;
      w_rd_ptr_nxt    = '0;
      w_count_nxt     = '0;
      w_overflow_nxt  = 1'b0;
      w_underflow_nxt = 1'b0;
    end else begin
      if (w_wr_accept) w_wr_ptr_nxt = r_wr_ptr + AddrW'(1);
      if (w_rd_accept) w_rd_ptr_nxt = r_rd_ptr + AddrW'(STRIDE);
      w_count_nxt = r_count + CountW'(w_wr_accept)
                    - (w_rd_accept ? CountW'(STRIDE) : CountW'(0));
      if (io_bus.i_data_valid && w_full)      w_overflow_nxt  = 1'b1;
      if (io_bus.i_rd_data && !w_win_valid)   w_underflow_nxt = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_count     <= w_count_nxt;
      r_overflow  <= w_overflow_nxt;
      r_underflow <= w_underflow_nxt;
    end
  end

  lb_window_mem #(
    .DATA_W (DataW),
    .DEPTH  (DEPTH),
    .KERNEL (KERNEL)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_mem_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (io_bus.i_data),
    .i_raddr (r_rd_ptr),
    .o_rdata (io_bus.o_data)
  );

  assign io_bus.o_full      = w_full;
  assign io_bus.o_win_valid = w_win_valid;
  assign io_bus.o_count     = r_count;
  assign io_bus.o_overflow  = r_overflow;
  assign io_bus.o_underflow = r_underflow;

endmodule

// File: tb/tb_window_line_buffer.sv
// Bench for window_line_buffer: directed scenarios on three geometries plus a
// randomized run against a sample-queue model.
module tb_window_line_buffer;

  localparam int unsigned DW = 13;

  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  window_line_buffer_if #(.DATA_W(DW), .KERNEL(3), .COUNT_W(10)) if_def ();
  window_line_buffer_if #(.DATA_W(DW), .KERNEL(3), .COUNT_W(4))  if_d8 ();
  window_line_buffer_if #(.DATA_W(DW), .KERNEL(3), .COUNT_W(4))  if_s2 ();

  window_line_buffer u_def (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (if_def)
  );

  window_line_buffer #(.DEPTH(8)) u_d8 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (if_d8)
  );

  window_line_buffer #(.DEPTH(8), .STRIDE(2)) u_s2 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (if_s2)
  );

  function automatic logic [3*DW-1:0] win3(input int a, input int b, input int c);
    return {DW'(a), DW'(b), DW'(c)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_def(input logic v, input int d, input logic r);
    if_def.i_data_valid = v; if_def.i_data = DW'(d); if_def.i_rd_data = r;
    tick();
    if_def.i_data_valid = 1'b0; if_def.i_rd_data = 1'b0;
  endtask

  task automatic drive_d8(input logic v, input int d, input logic r);
    if_d8.i_data_valid = v; if_d8.i_data = DW'(d); if_d8.i_rd_data = r;
    tick();
    if_d8.i_data_valid = 1'b0; if_d8.i_rd_data = 1'b0;
  endtask

  task automatic drive_s2(input logic v, input int d, input logic r);
    if_s2.i_data_valid = v; if_s2.i_data = DW'(d); if_s2.i_rd_data = r;
    tick();
    if_s2.i_data_valid = 1'b0; if_s2.i_rd_data = 1'b0;
  endtask

  task automatic clear_all();
    if_def.i_clear = 1'b1; if_d8.i_clear = 1'b1; if_s2.i_clear = 1'b1;
    tick();
    if_def.i_clear = 1'b0; if_d8.i_clear = 1'b0; if_s2.i_clear = 1'b0;
  endtask

  // Status vectors: {count, full, win_valid, overflow, underflow}
  task automatic test_reset();
    n_total++;
    if ({if_def.o_count, if_def.o_full, if_def.o_win_valid, if_def.o_overflow,
         if_def.o_underflow} !== 14'd0)
      $display("FAIL reset_def: count=%0d full=%b winv=%b", if_def.o_count, if_def.o_full,
               if_def.o_win_valid);
    else n_pass++;
    n_total++;
    if ({if_d8.o_count, if_d8.o_full, if_d8.o_win_valid, if_d8.o_overflow,
         if_d8.o_underflow} !== 8'd0)
      $display("FAIL reset_d8: count=%0d full=%b winv=%b", if_d8.o_count, if_d8.o_full,
               if_d8.o_win_valid);
    else n_pass++;
    n_total++;
    if ({if_s2.o_count, if_s2.o_full, if_s2.o_win_valid, if_s2.o_overflow,
         if_s2.o_underflow} !== 8'd0)
      $display("FAIL reset_s2: count=%0d full=%b winv=%b", if_s2.o_count, if_s2.o_full,
               if_s2.o_win_valid);
    else n_pass++;
  endtask

  task automatic test_basic();
    clear_all();
    drive_def(1'b1, 1, 1'b0);
    drive_def(1'b1, 2, 1'b0);
    n_total++;
    if (if_def.o_win_valid !== 1'b0)
      $display("FAIL basic_two_no_win: winv=%b want 0", if_def.o_win_valid);
    else n_pass++;
    drive_def(1'b1, 3, 1'b0);
    n_total++;
    if (if_def.o_win_valid !== 1'b1) $display("FAIL basic_winv: got %b want 1", if_def.o_win_valid);
    else n_pass++;
    n_total++;
    if (if_def.o_data !== win3(1, 2, 3))
      $display("FAIL basic_data: got %h want %h", if_def.o_data, win3(1, 2, 3));
    else n_pass++;
    n_total++;
    if (if_def.o_count !== 10'd3) $display("FAIL basic_count: got %0d want 3", if_def.o_count);
    else n_pass++;
    drive_def(1'b0, 0, 1'b1);
    n_total++;
    if ({if_def.o_count, if_def.o_win_valid} !== {10'd2, 1'b0})
      $display("FAIL basic_read: count=%0d winv=%b want 2/0", if_def.o_count, if_def.o_win_valid);
    else n_pass++;
  endtask

  task automatic test_overflow();
    clear_all();
    for (int i = 0; i < 8; i++) drive_d8(1'b1, 10 + i, 1'b0);
    n_total++;
    if ({if_d8.o_full, if_d8.o_count} !== {1'b1, 4'd8})
      $display("FAIL ovf_full: full=%b count=%0d want 1/8", if_d8.o_full, if_d8.o_count);
    else n_pass++;
    drive_d8(1'b1, 77, 1'b0);
    n_total++;
    if ({if_d8.o_overflow, if_d8.o_count} !== {1'b1, 4'd8})
      $display("FAIL ovf_drop: ovf=%b count=%0d want 1/8", if_d8.o_overflow, if_d8.o_count);
    else n_pass++;
    n_total++;
    if (if_d8.o_data !== win3(10, 11, 12))
      $display("FAIL ovf_mem_intact: got %h want %h", if_d8.o_data, win3(10, 11, 12));
    else n_pass++;
  endtask

  // Continues from the full buffer left by test_overflow (10..17).
  task automatic test_full_rw();
    drive_d8(1'b1, 99, 1'b1);
    n_total++;
    if ({if_d8.o_count, if_d8.o_full} !== {4'd7, 1'b0})
      $display("FAIL full_rw_count: count=%0d full=%b want 7/0", if_d8.o_count, if_d8.o_full);
    else n_pass++;
    n_total++;
    if (if_d8.o_data !== win3(11, 12, 13))
      $display("FAIL full_rw_data: got %h want %h", if_d8.o_data, win3(11, 12, 13));
    else n_pass++;
    drive_d8(1'b0, 0, 1'b1);
    drive_d8(1'b0, 0, 1'b1);
    drive_d8(1'b1, 50, 1'b1);
    n_total++;
    if (if_d8.o_count !== 4'd5) $display("FAIL mid_rw_count: got %0d want 5", if_d8.o_count);
    else n_pass++;
    n_total++;
    if (if_d8.o_data !== win3(14, 15, 16))
      $display("FAIL mid_rw_data: got %h want %h", if_d8.o_data, win3(14, 15, 16));
    else n_pass++;
    drive_d8(1'b0, 0, 1'b1);
    drive_d8(1'b0, 0, 1'b1);
    n_total++;
    if (if_d8.o_data !== win3(16, 17, 50))
      $display("FAIL full_rw_reject: got %h want %h", if_d8.o_data, win3(16, 17, 50));
    else n_pass++;
  endtask

  task automatic test_wrap();
    clear_all();
    for (int i = 0; i < 8; i++) drive_d8(1'b1, i, 1'b0);
    for (int i = 0; i < 6; i++) drive_d8(1'b0, 0, 1'b1);
    drive_d8(1'b1, 8, 1'b0);
    drive_d8(1'b1, 9, 1'b0);
    n_total++;
    if (if_d8.o_data !== win3(6, 7, 8))
      $display("FAIL wrap_data: got %h want %h", if_d8.o_data, win3(6, 7, 8));
    else n_pass++;
    n_total++;
    if ({if_d8.o_count, if_d8.o_overflow} !== {4'd4, 1'b0})
      $display("FAIL wrap_count: count=%0d ovf=%b want 4/0", if_d8.o_count, if_d8.o_overflow);
    else n_pass++;
  endtask

  task automatic test_stride();
    clear_all();
    for (int i = 1; i <= 5; i++) drive_s2(1'b1, i, 1'b0);
    drive_s2(1'b0, 0, 1'b1);
    n_total++;
    if ({if_s2.o_data, if_s2.o_count} !== {win3(3, 4, 5), 4'd3})
      $display("FAIL stride_data: got %h/%0d want %h/3", if_s2.o_data, if_s2.o_count,
               win3(3, 4, 5));
    else n_pass++;
    // Three samples still form a full window, so this read is taken.
    drive_s2(1'b0, 0, 1'b1);
    n_total++;
    if ({if_s2.o_count, if_s2.o_win_valid, if_s2.o_underflow} !== {4'd1, 1'b0, 1'b0})
      $display("FAIL stride_second: count=%0d winv=%b unf=%b want 1/0/0", if_s2.o_count,
               if_s2.o_win_valid, if_s2.o_underflow);
    else n_pass++;
    drive_s2(1'b0, 0, 1'b1);
    drive_s2(1'b0, 0, 1'b0);
    n_total++;
    if ({if_s2.o_count, if_s2.o_underflow} !== {4'd1, 1'b1})
      $display("FAIL stride_underflow: count=%0d unf=%b want 1/1", if_s2.o_count,
               if_s2.o_underflow);
    else n_pass++;
  endtask

  task automatic test_clear_reset();
    clear_all();
    for (int i = 0; i < 3; i++) drive_d8(1'b1, 20 + i, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if ({if_d8.o_count, if_d8.o_win_valid} !== {4'd0, 1'b0})
      $display("FAIL async_reset: count=%0d winv=%b want 0/0", if_d8.o_count, if_d8.o_win_valid);
    else n_pass++;
    #1 rst_n = 1'b1;
    drive_d8(1'b1, 1, 1'b0);
    drive_d8(1'b1, 2, 1'b1);
    n_total++;
    if ({if_d8.o_count, if_d8.o_underflow} !== {4'd2, 1'b1})
      $display("FAIL pre_clear: count=%0d unf=%b want 2/1", if_d8.o_count, if_d8.o_underflow);
    else n_pass++;
    if_d8.i_clear = 1'b1; if_d8.i_data_valid = 1'b1; if_d8.i_data = DW'(5);
    tick();
    if_d8.i_clear = 1'b0; if_d8.i_data_valid = 1'b0;
    n_total++;
    if ({if_d8.o_count, if_d8.o_underflow, if_d8.o_overflow} !== {4'd0, 1'b0, 1'b0})
      $display("FAIL clear_prio: count=%0d unf=%b ovf=%b want 0/0/0", if_d8.o_count,
               if_d8.o_underflow, if_d8.o_overflow);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [DW-1:0] mq [2][$];
    logic          movf [2];
    logic          munf [2];
    logic          v [2], r [2], c [2];
    logic [DW-1:0] dat [2];
    logic [7:0]    act_st, exp_st;
    logic [3*DW-1:0] act_win, exp_win;
    int            wp, rp, sz;
    clear_all();
    for (int d = 0; d < 2; d++) begin
      mq[d].delete(); movf[d] = 1'b0; munf[d] = 1'b0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      wp = ((cyc / 50) % 2 == 0) ? 75 : 30;
      rp = 100 - wp;
      for (int d = 0; d < 2; d++) begin
        v[d]   = ($urandom_range(0, 99) < wp);
        r[d]   = ($urandom_range(0, 99) < rp);
        c[d]   = ($urandom_range(0, 99) < 2);
        dat[d] = DW'($urandom);
        sz = mq[d].size();
        if (c[d]) begin
          mq[d].delete(); movf[d] = 1'b0; munf[d] = 1'b0;
        end else begin
          if (v[d] && sz == 8) movf[d] = 1'b1;
          if (r[d] && sz < 3) munf[d] = 1'b1;
          if (r[d] && sz >= 3) repeat (d + 1) void'(mq[d].pop_front());
          if (v[d] && sz < 8) mq[d].push_back(dat[d]);
        end
      end
      if_d8.i_clear = c[0]; if_d8.i_data_valid = v[0]; if_d8.i_rd_data = r[0];
      if_d8.i_data = dat[0];
      if_s2.i_clear = c[1]; if_s2.i_data_valid = v[1]; if_s2.i_rd_data = r[1];
      if_s2.i_data = dat[1];
      tick();
      if_d8.i_clear = 1'b0; if_d8.i_data_valid = 1'b0; if_d8.i_rd_data = 1'b0;
      if_s2.i_clear = 1'b0; if_s2.i_data_valid = 1'b0; if_s2.i_rd_data = 1'b0;
      for (int d = 0; d < 2; d++) begin
        sz = mq[d].size();
        exp_st = {4'(sz), sz == 8, sz >= 3, movf[d], munf[d]};
        act_st = (d == 0) ?
          {if_d8.o_count, if_d8.o_full, if_d8.o_win_valid, if_d8.o_overflow, if_d8.o_underflow} :
          {if_s2.o_count, if_s2.o_full, if_s2.o_win_valid, if_s2.o_overflow, if_s2.o_underflow};
        n_total++;
        if (act_st !== exp_st)
          $display("FAIL rand_status[%0d] cyc %0d: got %b want %b", d, cyc, act_st, exp_st);
        else n_pass++;
        if (sz >= 3) begin
          exp_win = {mq[d][0], mq[d][1], mq[d][2]};
          act_win = (d == 0) ? if_d8.o_data : if_s2.o_data;
          n_total++;
          if (act_win !== exp_win)
            $display("FAIL rand_window[%0d] cyc %0d: got %h want %h", d, cyc, act_win, exp_win);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    if_def.i_clear = 1'b0; if_def.i_data_valid = 1'b0; if_def.i_rd_data = 1'b0; if_def.i_data = '0;
    if_d8.i_clear  = 1'b0; if_d8.i_data_valid  = 1'b0; if_d8.i_rd_data  = 1'b0; if_d8.i_data  = '0;
    if_s2.i_clear  = 1'b0; if_s2.i_data_valid  = 1'b0; if_s2.i_rd_data  = 1'b0; if_s2.i_data  = '0;
    #3;
    test_reset();
    #4 rst_n = 1'b1;
    tick();
    test_basic();
    test_overflow();
    test_full_rw();
    test_wrap();
    test_stride();
    test_clear_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
